// File: rtl/mem_port_arbiter.sv
// Shared-memory arbiter alternating instruction fetch and data phases.
// Registers memory read data into held instruction and data words.
module mem_port_arbiter #(
  parameter int          N   = 32,
  parameter logic [31:0] NOP = 32'h00000033
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] data_addr,
  input  logic         data_read,
  input  logic         data_write,
  input  logic [N-1:0] data_wdata,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [N-1:0] mem_wdata,
  output logic         phase,
  output logic         pc_en,
  output logic [N-1:0] inst_out,
  output logic         inst_valid,
  output logic [N-1:0] data_out,
  output logic         data_valid
);

  logic         r_phase;
  logic [N-1:0] r_inst;
  logic         r_inst_vld;
  logic [N-1:0] r_data;
  logic         r_data_vld;
  logic         w_rd;

  // Store wins over a simultaneous load request.
  assign w_rd = r_phase ? (data_read & ~data_write) : 1'b1;

  always_comb begin
    mem_addr  = pc;
    mem_wdata = '0;
    mem_write = 1'b0;
    if (r_phase) begin
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_write = data_write & ~stall;
    end
  end

  assign mem_read   = w_rd;
  assign phase      = r_phase;
  assign pc_en      = r_phase & ~stall;
  assign inst_out   = r_inst;
  assign inst_valid = r_inst_vld;
  assign data_out   = r_data;
  assign data_valid = r_data_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= 1'b0;
      r_inst     <= NOP[N-1:0];
      r_inst_vld <= 1'b0;
      r_data     <= '0;
      r_data_vld <= 1'b0;
    end else begin
      r_inst_vld <= 1'b0;
      r_data_vld <= 1'b0;
      if (!stall) begin
        r_phase <= ~r_phase;
        if (flush) begin
          r_inst <= NOP[N-1:0];
        end else if (!r_phase) begin
          r_inst     <= mem_rdata;
          r_inst_vld <= 1'b1;
        end
        if (r_phase && w_rd) begin
          r_data     <= mem_rdata;
          r_data_vld <= 1'b1;
        end
      end
    end
  end

endmodule
